// File: rtl/fft_8p_seq.sv
// fft_8p_seq -- sequential 8-point radix-2 DIT FFT, one butterfly per cycle.
//
// A frame of eight complex samples is loaded into an in-place register file
// (bit-reversed order), transformed by 12 butterfly operations (3 stages x 4
// butterflies) using a single shared butterfly, then unloaded in natural bin
// order k = 0..7.
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   rst        synchronous active-high reset (priority over every handshake)
//   in_valid   input sample present
//   in_ready   block accepts an input sample this cycle (LOAD only)
//   in_real    input sample real part, signed Q(DATA_WIDTH-FRAC_WIDTH).FRAC_WIDTH
//   in_imag    input sample imaginary part, same format
//   out_valid  output bin present (UNLOAD only)
//   out_ready  downstream accepts the output bin
//   out_real   output bin X[k] real part, signed
//   out_imag   output bin X[k] imaginary part, signed
//   out_idx    bin index k of the presented output
//   out_last   high with out_valid when out_idx = 7
//   busy       high for the 12 COMPUTE cycles
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds payload stable while valid & !ready; ready
// here depends only on the FSM state, never combinationally on valid.

module fft_8p_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_real,
    input  logic signed [DATA_WIDTH-1:0] in_imag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_real,
    output logic signed [DATA_WIDTH-1:0] out_imag,
    output logic [2:0]                   out_idx,
    output logic                         out_last,
    output logic                         busy
);

    // FSM encoding; 'state' is a plain named register so checkers can bind to it.
    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_UNLOAD  = 2'd2;

    // Full-precision product sum width.
    localparam int PW = 2 * DATA_WIDTH + 1;

    // cos(pi/4) * 2^FRAC_WIDTH rounded to nearest, using 46341/65536 ~= 1/sqrt(2).
    localparam longint C45_L = ((64'sd46341 <<< FRAC_WIDTH) + 64'sd32768) >>> 16;
    localparam logic signed [DATA_WIDTH-1:0] TW_ONE = DATA_WIDTH'(64'sd1 <<< FRAC_WIDTH);
    localparam logic signed [DATA_WIDTH-1:0] TW_C45 = DATA_WIDTH'(C45_L);

    logic [1:0] state;
    logic [2:0] ld_cnt;
    logic [3:0] bf_cnt;

    // In-place complex register file.
    logic signed [DATA_WIDTH-1:0] reg_re [8];
    logic signed [DATA_WIDTH-1:0] reg_im [8];

    // ------------------------------------------------------------------
    // Load addressing: n-th sample lands in register bitrev3(n).
    // ------------------------------------------------------------------
    logic [2:0] ld_addr;
    assign ld_addr = {ld_cnt[0], ld_cnt[1], ld_cnt[2]};

    // ------------------------------------------------------------------
    // Butterfly scheduling: bf_cnt = {stage, butterfly}.
    //   span = 2^stage
    //   top  = (b div span)*2*span + (b mod span), bot = top + span
    //   k    = (b mod span) * (4 >> stage)
    // Each stage collapses to a fixed bit arrangement of b.
    // ------------------------------------------------------------------
    logic [1:0] stage;
    logic [1:0] bfly;
    logic [2:0] top;
    logic [2:0] bot;
    logic [1:0] tw_k;

    assign stage = bf_cnt[3:2];
    assign bfly  = bf_cnt[1:0];

    always_comb begin
        top  = 3'd0;
        bot  = 3'd0;
        tw_k = 2'd0;
        case (stage)
            2'd0: begin
                top  = {bfly, 1'b0};
                bot  = {bfly, 1'b1};
                tw_k = 2'd0;
            end
            2'd1: begin
                top  = {bfly[1], 1'b0, bfly[0]};
                bot  = {bfly[1], 1'b1, bfly[0]};
                tw_k = {bfly[0], 1'b0};
            end
            default: begin
                top  = {1'b0, bfly};
                bot  = {1'b1, bfly};
                tw_k = bfly;
            end
        endcase
    end

    // Twiddle W8^k = cos(2*pi*k/8) - j*sin(2*pi*k/8).
    logic signed [DATA_WIDTH-1:0] tw_re;
    logic signed [DATA_WIDTH-1:0] tw_im;

    always_comb begin
        tw_re = TW_ONE;
        tw_im = '0;
        case (tw_k)
            2'd0: begin
                tw_re = TW_ONE;
                tw_im = '0;
            end
            2'd1: begin
                tw_re = TW_C45;
                tw_im = -TW_C45;
            end
            2'd2: begin
                tw_re = '0;
                tw_im = -TW_ONE;
            end
            default: begin
                tw_re = -TW_C45;
                tw_im = -TW_C45;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Butterfly datapath: P = W * B, then A + P / A - P.
    // ------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] a_re;
    logic signed [DATA_WIDTH-1:0] a_im;
    logic signed [DATA_WIDTH-1:0] b_re;
    logic signed [DATA_WIDTH-1:0] b_im;

    assign a_re = reg_re[top];
    assign a_im = reg_im[top];
    assign b_re = reg_re[bot];
    assign b_im = reg_im[bot];

    // Sign-extend operands so each product is formed at full precision.
    logic signed [2*DATA_WIDTH-1:0] tw_re_w;
    logic signed [2*DATA_WIDTH-1:0] tw_im_w;
    logic signed [2*DATA_WIDTH-1:0] b_re_w;
    logic signed [2*DATA_WIDTH-1:0] b_im_w;

    assign tw_re_w = (2*DATA_WIDTH)'(tw_re);
    assign tw_im_w = (2*DATA_WIDTH)'(tw_im);
    assign b_re_w  = (2*DATA_WIDTH)'(b_re);
    assign b_im_w  = (2*DATA_WIDTH)'(b_im);

    logic signed [2*DATA_WIDTH-1:0] m_rr;
    logic signed [2*DATA_WIDTH-1:0] m_ii;
    logic signed [2*DATA_WIDTH-1:0] m_ri;
    logic signed [2*DATA_WIDTH-1:0] m_ir;

    assign m_rr = tw_re_w * b_re_w;
    assign m_ii = tw_im_w * b_im_w;
    assign m_ri = tw_re_w * b_im_w;
    assign m_ir = tw_im_w * b_re_w;

    logic signed [PW-1:0] p_re_full;
    logic signed [PW-1:0] p_im_full;

    assign p_re_full = PW'(m_rr) - PW'(m_ii);
    assign p_im_full = PW'(m_ri) + PW'(m_ir);

    // Arithmetic shift right by FRAC_WIDTH then truncation to DATA_WIDTH is
    // exactly this bit slice (floor toward -inf, wrap on overflow).
    logic signed [DATA_WIDTH-1:0] p_re;
    logic signed [DATA_WIDTH-1:0] p_im;

    assign p_re = p_re_full[FRAC_WIDTH +: DATA_WIDTH];
    assign p_im = p_im_full[FRAC_WIDTH +: DATA_WIDTH];

    // Discarded fraction and overflow bits of the products.
    logic unused_p_bits;
    assign unused_p_bits = ^{p_re_full[FRAC_WIDTH-1:0], p_re_full[PW-1:FRAC_WIDTH+DATA_WIDTH],
                             p_im_full[FRAC_WIDTH-1:0], p_im_full[PW-1:FRAC_WIDTH+DATA_WIDTH]};

    // Results wrap modulo 2^DATA_WIDTH: no saturation, no scaling.
    logic signed [DATA_WIDTH-1:0] sum_re;
    logic signed [DATA_WIDTH-1:0] sum_im;
    logic signed [DATA_WIDTH-1:0] dif_re;
    logic signed [DATA_WIDTH-1:0] dif_im;

    assign sum_re = a_re + p_re;
    assign sum_im = a_im + p_im;
    assign dif_re = a_re - p_re;
    assign dif_im = a_im - p_im;

    // ------------------------------------------------------------------
    // Sequential state: FSM, counters, register file.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_LOAD;
            ld_cnt  <= 3'd0;
            bf_cnt  <= 4'd0;
            out_idx <= 3'd0;
            for (int i = 0; i < 8; i++) begin
                reg_re[i] <= '0;
                reg_im[i] <= '0;
            end
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_valid) begin
                        reg_re[ld_addr] <= in_real;
                        reg_im[ld_addr] <= in_imag;
                        ld_cnt          <= ld_cnt + 3'd1;
                        if (ld_cnt == 3'd7) begin
                            state  <= ST_COMPUTE;
                            bf_cnt <= 4'd0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    reg_re[top] <= sum_re;
                    reg_im[top] <= sum_im;
                    reg_re[bot] <= dif_re;
                    reg_im[bot] <= dif_im;
                    if (bf_cnt == 4'd11) begin
                        state   <= ST_UNLOAD;
                        bf_cnt  <= 4'd0;
                        out_idx <= 3'd0;
                    end else begin
                        bf_cnt <= bf_cnt + 4'd1;
                    end
                end
                ST_UNLOAD: begin
                    if (out_ready) begin
                        if (out_idx == 3'd7) begin
                            state   <= ST_LOAD;
                            ld_cnt  <= 3'd0;
                            out_idx <= 3'd0;
                        end else begin
                            out_idx <= out_idx + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registered state, so they are stable while
    // out_valid & !out_ready.
    // ------------------------------------------------------------------
    assign in_ready  = (state == ST_LOAD);
    assign busy      = (state == ST_COMPUTE);
    assign out_valid = (state == ST_UNLOAD);
    assign out_last  = out_valid && (out_idx == 3'd7);
    assign out_real  = reg_re[out_idx];
    assign out_imag  = reg_im[out_idx];

endmodule

// File: tb/tb_fft_8p_seq.sv
// tb_fft_8p_seq -- self-checking bench for fft_8p_seq.
// Reference: a loop-based radix-2 DIT FFT on plain integer arrays built from
// the stage/butterfly/twiddle formulas, bit-exact with truncation and wrap.

module tb_fft_8p_seq;

    localparam int DW = 16;
    localparam int FW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_real;
    logic signed [DW-1:0] in_imag;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_real;
    logic signed [DW-1:0] out_imag;
    logic [2:0]           out_idx;
    logic                 out_last;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    // Expected bins of the frame in flight: {real, imag}.
    logic [2*DW-1:0] exp_q[$];

    // Current frame samples.
    int x_re[8];
    int x_im[8];

    int tw_re[4] = '{256, 181, 0, -181};
    int tw_im[4] = '{0, -181, -256, -181};

    fft_8p_seq #(.DATA_WIDTH(DW), .FRAC_WIDTH(FW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int wrap16(input longint v);
        logic [15:0] t;
        t = v[15:0];
        return int'($signed(t));
    endfunction

    function automatic int rnd16();
        logic [15:0] t;
        t = 16'($urandom);
        return int'($signed(t));
    endfunction

    function automatic int bitrev3(input int n);
        return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
    endfunction

    task automatic model_push();
        int ar[8];
        int ai[8];
        for (int n = 0; n < 8; n++) begin
            ar[bitrev3(n)] = x_re[n];
            ai[bitrev3(n)] = x_im[n];
        end
        for (int s = 0; s < 3; s++) begin
            for (int b = 0; b < 4; b++) begin
                int span;
                int t;
                int u;
                int k;
                int tr;
                int ti;
                longint pr;
                longint pi;
                span = 1 << s;
                t    = (b / span) * 2 * span + (b % span);
                u    = t + span;
                k    = (b % span) * (4 >> s);
                pr   = (longint'(tw_re[k]) * ar[u] - longint'(tw_im[k]) * ai[u]) >>> FW;
                pi   = (longint'(tw_re[k]) * ai[u] + longint'(tw_im[k]) * ar[u]) >>> FW;
                tr   = ar[t];
                ti   = ai[t];
                ar[t] = wrap16(tr + pr);
                ai[t] = wrap16(ti + pi);
                ar[u] = wrap16(tr - pr);
                ai[u] = wrap16(ti - pi);
            end
        end
        for (int k = 0; k < 8; k++) exp_q.push_back({16'(ar[k]), 16'(ai[k])});
    endtask

    // ---------------- drivers ----------------
    // Feeds x_re/x_im; on return the 8th accept happens at the next rising edge.
    task automatic drive_samples(input bit gaps);
        int i = 0;
        int guard = 0;
        while (i < 8 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_real  = 16'($urandom);
                in_imag  = 16'($urandom);
            end else begin
                in_valid = 1'b1;
                in_real  = 16'(x_re[i]);
                in_imag  = 16'(x_im[i]);
            end
            if (in_valid && in_ready) i++;
        end
        checks++;
        if (i != 8) begin
            errors++;
            $display("FAIL load_timeout accepted=%0d required=8", i);
        end
    endtask

    // Waits for the first out_valid; checks latency and busy length.
    task automatic wait_results(input bit hold);
        int cyc = 0;
        int busy_n = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_n++;
            if (busy) begin
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL compute_flags out_valid=%b in_ready=%b required 0 0", out_valid, in_ready);
                end
            end
            in_valid = hold;
            in_real  = 16'($urandom);
            in_imag  = 16'($urandom);
        end
        checks++;
        if (cyc != 13) begin
            errors++;
            $display("FAIL first_valid_latency got=%0d required=13", cyc);
        end
        checks++;
        if (busy_n != 12) begin
            errors++;
            $display("FAIL busy_cycles got=%0d required=12", busy_n);
        end
    endtask

    // Drains 8 bins against exp_q with optional back-pressure.
    task automatic drain_bins(input bit bp, input bit hold);
        logic [2*DW-1:0] held;
        logic [2:0]      held_idx;
        bit              stalled = 1'b0;
        int              e = 0;
        int              guard = 0;
        held     = '0;
        held_idx = '0;
        while (e < 8 && guard < 400) begin
            guard++;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL unload_flags valid=%b ready=%b busy=%b required 1 0 0", out_valid, in_ready, busy);
            end
            checks++;
            if (out_idx !== 3'(e)) begin
                errors++;
                $display("FAIL out_idx got=%0d required=%0d", out_idx, e);
            end
            checks++;
            if (out_last !== 1'(e == 7)) begin
                errors++;
                $display("FAIL out_last bin=%0d got=%b", e, out_last);
            end
            checks++;
            if ({out_real, out_imag} !== exp_q[0]) begin
                errors++;
                $display("FAIL bin%0d got=(%0d,%0d) required=(%0d,%0d)", e, out_real, out_imag,
                         $signed(exp_q[0][31:16]), $signed(exp_q[0][15:0]));
            end
            if (stalled) begin
                checks++;
                if ({out_real, out_imag} !== held || out_idx !== held_idx) begin
                    errors++;
                    $display("FAIL stall_hold got=%h/%0d required=%h/%0d", {out_real, out_imag}, out_idx, held, held_idx);
                end
            end
            out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            in_valid  = hold;
            in_real   = 16'($urandom);
            in_imag   = 16'($urandom);
            if (out_ready) begin
                void'(exp_q.pop_front());
                e++;
                stalled = 1'b0;
            end else begin
                stalled  = 1'b1;
                held     = {out_real, out_imag};
                held_idx = out_idx;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (e != 8) begin
            errors++;
            $display("FAIL unload_timeout bins=%0d required=8", e);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL back_to_load valid=%b ready=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic run_frame(input bit gaps, input bit bp, input bit hold);
        drive_samples(gaps);
        wait_results(hold);
        drain_bins(bp, hold);
    endtask

    task automatic set_impulse();
        for (int n = 0; n < 8; n++) begin
            x_re[n] = (n == 0) ? 256 : 0;
            x_im[n] = 0;
        end
        exp_q.delete();
        for (int k = 0; k < 8; k++) exp_q.push_back({16'd256, 16'd0});
    endtask

    task automatic set_dc();
        for (int n = 0; n < 8; n++) begin
            x_re[n] = 256;
            x_im[n] = 0;
        end
        exp_q.delete();
        exp_q.push_back({16'd2048, 16'd0});
        for (int k = 1; k < 8; k++) exp_q.push_back({16'd0, 16'd0});
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_real   = 16'sd999;
        in_imag   = 16'sd77;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b required=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL rst_out_last got=%b required=0", out_last); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b required=0", busy); end
        checks++;
        if (out_idx !== 3'd0) begin errors++; $display("FAIL rst_out_idx got=%0d required=0", out_idx); end
        checks++;
        if (out_real !== 16'sd0 || out_imag !== 16'sd0) begin
            errors++;
            $display("FAIL rst_out_data got=(%0d,%0d) required=(0,0)", out_real, out_imag);
        end
    endtask

    task automatic test_impulse();
        set_impulse();
        run_frame(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_dc();
        set_dc();
        run_frame(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_ramp();
        for (int n = 0; n < 8; n++) begin
            x_re[n] = (n + 1) * 256;
            x_im[n] = 256;
        end
        exp_q.delete();
        model_push();
        exp_q[0] = {16'd9216, 16'd2048};
        exp_q[4] = {16'(-1024), 16'd0};
        run_frame(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_handshake();
        for (int r = 0; r < 3; r++) begin
            set_dc();
            run_frame(1'b1, 1'b1, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int guard = 0;
        for (int i = 0; i < 8; i++) begin
            x_re[i] = rnd16();
            x_im[i] = rnd16();
        end
        drive_samples(1'b0);
        while (n < 5 && guard < 50) begin
            @(negedge clk);
            guard++;
            in_valid = 1'b0;
            if (busy) n++;
        end
        rst      = 1'b1;
        in_valid = 1'b1;
        in_real  = 16'sd999;
        in_imag  = 16'sd999;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flags ready=%b valid=%b busy=%b last=%b required 1 0 0 0",
                     in_ready, out_valid, busy, out_last);
        end
        checks++;
        if (out_idx !== 3'd0 || out_real !== 16'sd0 || out_imag !== 16'sd0) begin
            errors++;
            $display("FAIL midrst_data idx=%0d data=(%0d,%0d) required 0 (0,0)", out_idx, out_real, out_imag);
        end
        set_impulse();
        run_frame(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        for (int n = 0; n < 8; n++) begin
            x_re[n] = 32767;
            x_im[n] = 0;
        end
        exp_q.delete();
        model_push();
        exp_q[0] = {16'hFFF8, 16'd0};
        run_frame(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 4; f++) begin
            for (int n = 0; n < 8; n++) begin
                x_re[n] = rnd16();
                x_im[n] = rnd16();
            end
            exp_q.delete();
            model_push();
            run_frame(f[0], f[1], 1'b0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        out_ready = 1'b1;
        test_reset();
        test_impulse();
        test_dc();
        test_ramp();
        test_handshake();
        test_reset_mid();
        test_overflow();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
